// File: rtl/reg_file.sv
// reg_file: parametrised register file with one write port, two registered
// read ports (A/B, 1-cycle latency) and a per-register busy scoreboard.
//
// Optional feature: define REG_BYPASS_EN to forward same-cycle write data to
// a read of the same index (even if that register is busy). Without it, such
// a read sees the old stored value, or rbusy if the register is busy.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   we/waddr/wdata      write port; a write clears busy[waddr]
//   set_busy/set_idx    mark a register busy; set wins over a same-cycle clear
//   re_*/raddr_*        read requests, ports A and B
//   rdata_*/rvalid_*/rbusy_*  registered read response (one-cycle pulses)
//   busy_vec            busy bit per register after the most recent edge

// Per-port response register. Captures either the bypassed write data or the
// selected register value; a busy hit pulses rbusy and leaves rdata alone.
module reg_file_rport #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_re,
    input  logic              i_byp,
    input  logic              i_busy,
    input  logic [DATA_W-1:0] i_rdval,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rvalid,
    output logic              o_rbusy
);
    always_ff @(posedge clk) begin
        if (rst) begin
            o_rdata  <= '0;
            o_rvalid <= 1'b0;
            o_rbusy  <= 1'b0;
        end else begin
            o_rvalid <= 1'b0;
            o_rbusy  <= 1'b0;
            if (i_re) begin
                if (i_byp) begin
                    o_rdata  <= i_wdata;
                    o_rvalid <= 1'b1;
                end else if (i_busy) begin
                    o_rbusy  <= 1'b1;
                end else begin
                    o_rdata  <= i_rdval;
                    o_rvalid <= 1'b1;
                end
            end
        end
    end
endmodule

module reg_file #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic                  set_busy,
    input  logic [IDX_W-1:0]      set_idx,
    input  logic                  re_a,
    input  logic [IDX_W-1:0]      raddr_a,
    input  logic                  re_b,
    input  logic [IDX_W-1:0]      raddr_b,
    output logic [DATA_W-1:0]     rdata_a,
    output logic                  rvalid_a,
    output logic                  rbusy_a,
    output logic [DATA_W-1:0]     rdata_b,
    output logic                  rvalid_b,
    output logic                  rbusy_b,
    output logic [(2**IDX_W)-1:0] busy_vec
);
    localparam int NREG  = 2**IDX_W;
    localparam int NPORT = 2;

    logic [NREG-1:0][DATA_W-1:0]  r_mem;
    logic [NREG-1:0]              r_busy;
    logic [NREG-1:0]              w_busy_nxt;

    logic [NPORT-1:0]             w_re;
    logic [NPORT-1:0][IDX_W-1:0]  w_raddr;
    logic [NPORT-1:0]             w_byp;
    logic [NPORT-1:0][DATA_W-1:0] w_rdata;
    logic [NPORT-1:0]             w_rvalid;
    logic [NPORT-1:0]             w_rbusy;

    // Clear on write first, then set, so a same-cycle set wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (we)       w_busy_nxt[waddr]   = 1'b0;
        if (set_busy) w_busy_nxt[set_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem  <= '0;
            r_busy <= '0;
        end else begin
            if (we) r_mem[waddr] <= wdata;
            r_busy <= w_busy_nxt;
        end
    end

    assign busy_vec = r_busy;

    assign w_re    = {re_b, re_a};
    assign w_raddr = {raddr_b, raddr_a};

    for (genvar p = 0; p < NPORT; p++) begin : g_port
`ifdef REG_BYPASS_EN
        assign w_byp[p] = we && (waddr == w_raddr[p]);
`else
        assign w_byp[p] = 1'b0;
`endif
        reg_file_rport #(.DATA_W(DATA_W)) u_rport (
            .clk      (clk),
            .rst      (rst),
            .i_re     (w_re[p]),
            .i_byp    (w_byp[p]),
            .i_busy   (r_busy[w_raddr[p]]),
            .i_rdval  (r_mem[w_raddr[p]]),
            .i_wdata  (wdata),
            .o_rdata  (w_rdata[p]),
            .o_rvalid (w_rvalid[p]),
            .o_rbusy  (w_rbusy[p])
        );
    end

    assign rdata_a  = w_rdata[0];
    assign rvalid_a = w_rvalid[0];
    assign rbusy_a  = w_rbusy[0];
    assign rdata_b  = w_rdata[1];
    assign rvalid_b = w_rvalid[1];
    assign rbusy_b  = w_rbusy[1];
endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
    typedef struct {
        logic        busy;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 16x8 instance
    logic        rst, we, set_busy, re_a, re_b;
    logic [2:0]  waddr, set_idx, raddr_a, raddr_b;
    logic [15:0] wdata, rdata_a, rdata_b;
    logic        rvalid_a, rvalid_b, rbusy_a, rbusy_b;
    logic [7:0]  busy_vec;

    // 32x16 instance
    logic        rst2, we2, set_busy2, re_a2, re_b2;
    logic [3:0]  waddr2, set_idx2, raddr_a2, raddr_b2;
    logic [31:0] wdata2, rdata_a2, rdata_b2;
    logic        rvalid_a2, rvalid_b2, rbusy_a2, rbusy_b2;
    logic [15:0] busy_vec2;

    reg_file #(.DATA_W(16), .IDX_W(3)) dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .set_busy(set_busy), .set_idx(set_idx),
        .re_a(re_a), .raddr_a(raddr_a), .re_b(re_b), .raddr_b(raddr_b),
        .rdata_a(rdata_a), .rvalid_a(rvalid_a), .rbusy_a(rbusy_a),
        .rdata_b(rdata_b), .rvalid_b(rvalid_b), .rbusy_b(rbusy_b),
        .busy_vec(busy_vec)
    );

    reg_file #(.DATA_W(32), .IDX_W(4)) dut2 (
        .clk(clk), .rst(rst2), .we(we2), .waddr(waddr2), .wdata(wdata2),
        .set_busy(set_busy2), .set_idx(set_idx2),
        .re_a(re_a2), .raddr_a(raddr_a2), .re_b(re_b2), .raddr_b(raddr_b2),
        .rdata_a(rdata_a2), .rvalid_a(rvalid_a2), .rbusy_a(rbusy_a2),
        .rdata_b(rdata_b2), .rvalid_b(rvalid_b2), .rbusy_b(rbusy_b2),
        .busy_vec(busy_vec2)
    );

    int checks = 0;
    int errors = 0;

    exp_t qa[$], qb[$], qa2[$], qb2[$];
    // Last valid data per port: what rdata must hold on a busy response.
    logic [31:0] last_a, last_b, last_a2, last_b2;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_resp(input string nm, input logic gv, input logic gb,
                            input logic [31:0] gd, input exp_t e);
        checks++;
        if (gv !== !e.busy || gb !== e.busy || gd !== e.data) begin
            errors++;
            $display("FAIL %s got v=%b b=%b d=%h exp v=%b b=%b d=%h",
                     nm, gv, gb, gd, !e.busy, e.busy, e.data);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errors++;
        $display("FAIL %s unexpected response, got=1 exp=0", nm);
    endtask

    // Monitors: pop one expectation per presented response.
    always @(negedge clk) begin
        if (rvalid_a || rbusy_a) begin
            if (qa.size() == 0) unexpected("port_a");
            else chk_resp("port_a", rvalid_a, rbusy_a, {16'h0, rdata_a}, qa.pop_front());
        end
        if (rvalid_b || rbusy_b) begin
            if (qb.size() == 0) unexpected("port_b");
            else chk_resp("port_b", rvalid_b, rbusy_b, {16'h0, rdata_b}, qb.pop_front());
        end
        if (rvalid_a2 || rbusy_a2) begin
            if (qa2.size() == 0) unexpected("port_a32");
            else chk_resp("port_a32", rvalid_a2, rbusy_a2, rdata_a2, qa2.pop_front());
        end
        if (rvalid_b2 || rbusy_b2) begin
            if (qb2.size() == 0) unexpected("port_b32");
            else chk_resp("port_b32", rvalid_b2, rbusy_b2, rdata_b2, qb2.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk); #1;
        we = 0; set_busy = 0; re_a = 0; re_b = 0;
        we2 = 0; set_busy2 = 0; re_a2 = 0; re_b2 = 0;
    endtask

    // Expectation pushes: b=1 means a busy response expected.
    task automatic rd_a(input logic [2:0] idx, input logic b, input logic [31:0] d);
        exp_t e;
        re_a = 1; raddr_a = idx;
        e.busy = b;
        if (!b) last_a = d;
        e.data = last_a;
        qa.push_back(e);
    endtask

    task automatic rd_b(input logic [2:0] idx, input logic b, input logic [31:0] d);
        exp_t e;
        re_b = 1; raddr_b = idx;
        e.busy = b;
        if (!b) last_b = d;
        e.data = last_b;
        qb.push_back(e);
    endtask

    task automatic rd_a2(input logic [3:0] idx, input logic [31:0] d);
        exp_t e;
        re_a2 = 1; raddr_a2 = idx;
        e.busy = 0; last_a2 = d; e.data = d;
        qa2.push_back(e);
    endtask

    task automatic rd_b2(input logic [3:0] idx, input logic [31:0] d);
        exp_t e;
        re_b2 = 1; raddr_b2 = idx;
        e.busy = 0; last_b2 = d; e.data = d;
        qb2.push_back(e);
    endtask

    task automatic wr(input logic [2:0] idx, input logic [15:0] d);
        we = 1; waddr = idx; wdata = d;
    endtask

    initial begin
        rst = 1; we = 0; set_busy = 0; re_a = 1; re_b = 0;
        waddr = 0; set_idx = 0; raddr_a = 0; raddr_b = 0; wdata = 0;
        rst2 = 1; we2 = 0; set_busy2 = 0; re_a2 = 0; re_b2 = 0;
        waddr2 = 0; set_idx2 = 0; raddr_a2 = 0; raddr_b2 = 0; wdata2 = 0;
        last_a = 0; last_b = 0; last_a2 = 0; last_b2 = 0;
        // Reads during reset are ignored: no expectation pushed.
        @(posedge clk); #1; re_a = 1;
        @(posedge clk); #1;
        rst = 0; rst2 = 0; re_a = 0;
        chk("rst_rdata_a", {16'h0, rdata_a}, 32'h0);
        chk("rst_rvalid_a", {31'h0, rvalid_a}, 32'h0);
        chk("rst_rbusy_b", {31'h0, rbusy_b}, 32'h0);
        chk("rst_busy_vec", {24'h0, busy_vec}, 32'h0);

        // Read all registers after reset, back to back.
        for (int i = 0; i < 8; i++) begin
            rd_a(i[2:0], 0, 32'h0);
            tick();
        end

        // Write then read on both ports.
        wr(3, 16'hA5A5); tick();
        wr(6, 16'h1234); tick();
        rd_a(3, 0, 32'hA5A5); rd_b(6, 0, 32'h1234); tick();
        // Same index on both ports.
        rd_a(6, 0, 32'h1234); rd_b(6, 0, 32'h1234); tick();

        // Busy scoreboard.
        set_busy = 1; set_idx = 2; tick();
        chk("busy_set_r2", {31'h0, busy_vec[2]}, 32'h1);
        rd_a(2, 1, 32'h0); tick();
        wr(2, 16'h0F0F); tick();
        chk("busy_clr_r2", {31'h0, busy_vec[2]}, 32'h0);
        rd_a(2, 0, 32'h0F0F); tick();

        // Same-cycle read/write, idle register.
        wr(5, 16'h1111); tick();
        wr(5, 16'h2222);
`ifdef REG_BYPASS_EN
        rd_a(5, 0, 32'h2222); rd_b(5, 0, 32'h2222);
`else
        rd_a(5, 0, 32'h1111); rd_b(5, 0, 32'h1111);
`endif
        tick();
        rd_a(5, 0, 32'h2222); tick();

        // Same-cycle read/write of a busy register.
        set_busy = 1; set_idx = 1; tick();
        wr(1, 16'h4444);
`ifdef REG_BYPASS_EN
        rd_b(1, 0, 32'h4444);
`else
        rd_b(1, 1, 32'h0);
`endif
        tick();
        rd_b(1, 0, 32'h4444); tick();

        // Set/write collision: set wins.
        set_busy = 1; set_idx = 4; wr(4, 16'h7777); tick();
        chk("collide_busy_r4", {31'h0, busy_vec[4]}, 32'h1);
        chk("collide_busy_vec", {24'h0, busy_vec}, 32'h10);
        rd_a(4, 1, 32'h0); tick();
        wr(4, 16'h8888); tick();
        rd_a(4, 0, 32'h8888); tick();

        // Reset mid-operation: pending busy dropped, same-cycle read ignored.
        set_busy = 1; set_idx = 7; tick();
        chk("pre_rst_busy_r7", {31'h0, busy_vec[7]}, 32'h1);
        rst = 1; re_a = 1; raddr_a = 3; tick();
        rst = 0;
        chk("midrst_busy_vec", {24'h0, busy_vec}, 32'h0);
        chk("midrst_rdata_a", {16'h0, rdata_a}, 32'h0);
        last_a = 0; last_b = 0;
        rd_a(3, 0, 32'h0); rd_b(7, 0, 32'h0); tick();

        // Wide instance: 32-bit data, 16 registers.
        we2 = 1; waddr2 = 15; wdata2 = 32'hDEADBEEF; tick();
        rd_a2(15, 32'hDEADBEEF); rd_b2(15, 32'hDEADBEEF); tick();
        we2 = 1; waddr2 = 0; wdata2 = 32'h0000_0001; tick();
        rd_a2(15, 32'hDEADBEEF); rd_b2(0, 32'h0000_0001); tick();
        chk("wide_busy_vec", {16'h0, busy_vec2}, 32'h0);

        tick(); tick();
        chk("drain_qa", qa.size(), 0);
        chk("drain_qb", qb.size(), 0);
        chk("drain_qa32", qa2.size(), 0);
        chk("drain_qb32", qb2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
